// File: rtl/ddr_mem_pkg.sv
// Shared types for the burst DDR memory model: response codes, FSM states,
// and the byte-strobe width helper.
package ddr_mem_pkg;

  typedef enum logic [1:0] {
    OKAY   = 2'd0,
    SLVERR = 2'd1,
    CMDERR = 2'd2,
    PARERR = 2'd3
  } resp_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    READ  = 2'd2,
    DRAIN = 2'd3
  } state_t;

  function automatic int strb_w(input int dw);
    return dw / 8;
  endfunction

endpackage

// File: rtl/ddr_burst_memory_rd_pipe.sv
// Read-latency shift pipeline: RD_LATENCY stages of valid + payload,
// cleared asynchronously so a reset drops any beats still in flight.
module ddr_rd_pipe #(
  parameter int RD_LATENCY = 2,
  parameter int W          = 33
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  output logic [W-1:0] out_data
);

  logic [RD_LATENCY:1]        vld_pipe;
  logic [RD_LATENCY:1][W-1:0] dat_pipe;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vld_pipe <= '0;
      dat_pipe <= '0;
    end else begin
      vld_pipe[1] <= in_valid;
      dat_pipe[1] <= in_data;
      for (int i = 2; i <= RD_LATENCY; i++) begin
        vld_pipe[i] <= vld_pipe[i-1];
        dat_pipe[i] <= dat_pipe[i-1];
      end
    end
  end

  assign out_valid = vld_pipe[RD_LATENCY];
  assign out_data  = dat_pipe[RD_LATENCY];

endmodule

// File: rtl/ddr_burst_memory.sv
// Burst-capable DDR memory model with byte strobes, read-latency pipe and
// coded responses. Optional byte parity under `DDR_MEM_PARITY_EN.
module ddr_burst_memory
  import ddr_mem_pkg::*;
#(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 32,
  parameter int MEM_SIZE   = 16,
  parameter int BURST_MAX  = 4,
  parameter int RD_LATENCY = 2,
  localparam int NB = strb_w(DATA_WIDTH),
  localparam int LW = $clog2(BURST_MAX) + 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr,
  input  logic                  rd,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [LW-1:0]         burst_len,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [NB-1:0]         wstrb,
`ifdef DDR_MEM_PARITY_EN
  input  logic                  parity_inject,
`endif
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  rvalid,
  output logic                  busy,
  output logic                  done,
  output logic [1:0]            response
);

  if (MEM_SIZE > 2**ADDR_WIDTH) begin : g_size_chk
    $error("MEM_SIZE does not fit in ADDR_WIDTH");
  end
  if (DATA_WIDTH % 8 != 0) begin : g_dw_chk
    $error("DATA_WIDTH must be a multiple of 8");
  end

`ifdef DDR_MEM_PARITY_EN
  localparam int PW = DATA_WIDTH + NB + 1;
`else
  localparam int PW = DATA_WIDTH + 1;
`endif

  logic [DATA_WIDTH-1:0] mem [MEM_SIZE];

  state_t                state, state_n;
  logic [ADDR_WIDTH-1:0] cur_addr, cur_addr_n, beat_addr;
  logic [LW-1:0]         rem, rem_n;
  logic                  slv_q, slv_n, beat_slv;
  logic                  done_q, done_n, hold_q, hold_n;
  logic [1:0]            resp_q, resp_n, rd_resp;
  logic                  we, issue, issue_last, start_slv, cmd_err;
  logic [DATA_WIDTH-1:0] rd_word;
  logic [PW-1:0]         pipe_in, pipe_out;
  logic                  pipe_vld, rd_done;

  function automatic logic [ADDR_WIDTH-1:0] nxt(input logic [ADDR_WIDTH-1:0] a);
    return (int'(a) >= MEM_SIZE - 1) ? '0 : a + 1'b1;
  endfunction

  assign start_slv = int'(addr) >= MEM_SIZE;
  assign cmd_err   = (wr & rd) | (int'(burst_len) >= BURST_MAX);
  // hold_q keeps busy high through the done cycle of a multi-beat write
  assign busy      = (state != IDLE) | hold_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n    = state;
    cur_addr_n = cur_addr;
    rem_n      = rem;
    slv_n      = slv_q;
    done_n     = 1'b0;
    hold_n     = 1'b0;
    resp_n     = resp_q;
    we         = 1'b0;
    issue      = 1'b0;
    issue_last = 1'b0;
    beat_addr  = cur_addr;
    beat_slv   = slv_q;
    case (state)
      IDLE: begin
        beat_addr = addr;
        beat_slv  = start_slv;
        if (!hold_q && (wr || rd)) begin
          if (cmd_err) begin
            done_n = 1'b1;
            resp_n = CMDERR;
          end else begin
            slv_n      = start_slv;
            cur_addr_n = nxt(addr);
            rem_n      = burst_len;
            if (wr) begin
              we = 1'b1;
              if (burst_len == '0) begin
                done_n = 1'b1;
                resp_n = start_slv ? SLVERR : OKAY;
              end else begin
                state_n = WRITE;
              end
            end else begin
              issue      = 1'b1;
              issue_last = (burst_len == '0);
              state_n    = (burst_len == '0) ? DRAIN : READ;
            end
          end
        end
      end
      WRITE: begin
        if (wr) begin
          we         = 1'b1;
          cur_addr_n = nxt(cur_addr);
          rem_n      = rem - 1'b1;
          if (rem == LW'(1)) begin
            state_n = IDLE;
            done_n  = 1'b1;
            hold_n  = 1'b1;
            resp_n  = slv_q ? SLVERR : OKAY;
          end
        end
      end
      READ: begin
        issue      = 1'b1;
        cur_addr_n = nxt(cur_addr);
        rem_n      = rem - 1'b1;
        if (rem == LW'(1)) begin
          issue_last = 1'b1;
          state_n    = DRAIN;
        end
      end
      DRAIN: begin
        if (rd_done) begin
          state_n = IDLE;
          resp_n  = rd_resp;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cur_addr <= '0;
      rem      <= '0;
      slv_q    <= 1'b0;
      done_q   <= 1'b0;
      hold_q   <= 1'b0;
      resp_q   <= OKAY;
    end else begin
      cur_addr <= cur_addr_n;
      rem      <= rem_n;
      slv_q    <= slv_n;
      done_q   <= done_n;
      hold_q   <= hold_n;
      resp_q   <= resp_n;
    end
  end

  // Out-of-range beats never touch the array; reads of them return zero
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < MEM_SIZE; i++) mem[i] <= '0;
    end else if (we && !beat_slv) begin
      for (int b = 0; b < NB; b++)
        if (wstrb[b]) mem[int'(beat_addr)][8*b +: 8] <= wdata[8*b +: 8];
    end
  end

  assign rd_word = beat_slv ? '0 : mem[int'(beat_addr)];

`ifdef DDR_MEM_PARITY_EN
  logic [NB-1:0] par_mem [MEM_SIZE];
  logic [NB-1:0] rd_par, par_out, par_bad;
  logic          mism, par_acc;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < MEM_SIZE; i++) par_mem[i] <= '0;
    end else if (we && !beat_slv) begin
      for (int b = 0; b < NB; b++)
        if (wstrb[b])
          par_mem[int'(beat_addr)][b] <= (^wdata[8*b +: 8]) ^ ((b == 0) & parity_inject);
    end
  end

  assign rd_par  = beat_slv ? '0 : par_mem[int'(beat_addr)];
  assign pipe_in = {issue_last, rd_par, rd_word};
  assign par_out = pipe_out[DATA_WIDTH +: NB];

  always_comb begin
    par_bad = '0;
    for (int b = 0; b < NB; b++) par_bad[b] = (^rdata[8*b +: 8]) ^ par_out[b];
  end
  assign mism = pipe_vld & (|par_bad);

  // Sticky per-burst flag, cleared when a new read command starts
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                       par_acc <= 1'b0;
    else if (issue && state == IDLE)  par_acc <= 1'b0;
    else if (mism)                    par_acc <= 1'b1;
  end

  assign rd_resp = slv_q ? SLVERR : ((par_acc | mism) ? PARERR : OKAY);
`else
  assign pipe_in = {issue_last, rd_word};
  assign rd_resp = slv_q ? SLVERR : OKAY;
`endif

  ddr_rd_pipe #(
    .RD_LATENCY (RD_LATENCY),
    .W          (PW)
  ) u_rd_pipe (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (issue),
    .in_data   (pipe_in),
    .out_valid (pipe_vld),
    .out_data  (pipe_out)
  );

  assign rdata    = pipe_out[DATA_WIDTH-1:0];
  assign rvalid   = pipe_vld;
  assign rd_done  = pipe_vld & pipe_out[PW-1];
  assign done     = done_q | rd_done;
  assign response = rd_done ? rd_resp : resp_q;

endmodule
